ram_ctrl: RTL

- Request/response front-end sitting directly upstream of the single-port `ram`, which has a bidirectional `data` bus.
- Accepts write and read requests over a valid/ready handshake and sequences `ram`'s addr, wr_en and inout data.
- Owns tri-state control of the shared bus and returns read data on a separate valid/ready response channel.
- Gives system masters a clean, non-tri-state interface to the RAM.

---
 rtl/ram_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: valid/ready request front-end for a single-port RAM with a shared
// bidirectional data bus. Writes take one bus cycle; reads wait RD_LATENCY
// cycles, capture the bus and hold the word on a response channel until taken.
// Optional build macro: RAM_CTRL_TURNAROUND_EN inserts a one-cycle dead bus
// state (TURN) after each read response before the next request is accepted.
module ram_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr_en,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  busy
);

    localparam int CNT_W = 4;

`ifdef RAM_CTRL_TURNAROUND_EN
    typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, TURN} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  wr_en_q;
    logic                  rsp_valid_q;
    logic                  accept;
    logic                  rd_done;

    assign accept  = (state_q == IDLE) && req_valid;
    assign rd_done = (state_q == READ) && (cnt_q == '0);

    // req_ready is gated by rst_n so it reads 0 for the whole reset pulse
    assign req_ready = (state_q == IDLE) && rst_n;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign ram_addr  = addr_q;
    assign ram_wr_en = wr_en_q;

    // wr_en_q is both the RAM write strobe and the bus driver enable
    assign ram_data = wr_en_q ? wdata_q : 'z;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = req_we ? WRITE : READ;
            WRITE: state_d = IDLE;
            READ:  if (cnt_q == '0) state_d = RESP;
`ifdef RAM_CTRL_TURNAROUND_EN
            RESP:  if (rsp_ready) state_d = TURN;
            TURN:  state_d = IDLE;
`else
            RESP:  if (rsp_ready) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Request latch, latency counter, bus strobe and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (!req_we) cnt_q <= CNT_W'(RD_LATENCY - 1);
            end else if ((state_q == READ) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end

            wr_en_q <= (state_d == WRITE);

            if (rd_done) begin
                rdata_q     <= ram_data;
                rsp_valid_q <= 1'b1;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule
